// File: rtl/uart_rx_pkt_parser.sv
// uart_rx_pkt_parser: frames SYNC/LEN/payload/CHK packets from a UART byte strobe and forwards checksum-good payloads.
// Define UART_PKT_TIMEOUT_EN to abandon a packet after TIMEOUT_CLKS cycles without a byte.
module uart_rx_pkt_parser #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 2170
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Pyld_Valid,
    input  logic       i_Pyld_Ready,
    output logic [7:0] o_Pyld_Byte,
    output logic       o_Pyld_Last,
    output logic [7:0] o_Pkt_Len,
    output logic       o_Err_Chk,
    output logic       o_Err_Len,
    output logic       o_Overrun,
    output logic       o_Err_Timeout
);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d, sum_q, sum_d, idx_q, idx_d, rd_idx_q, rd_idx_d;
    logic       err_chk_q, err_chk_d, err_len_q, err_len_d, overrun_q, overrun_d;
    logic       wr_en, last, timeout;
    logic [7:0] mem_q [2**AW];

`ifdef UART_PKT_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CLKS - 1);
    logic [31:0] timer_q, timer_d;
    logic        err_timeout_q;

    // Counts only while a packet is being received; any byte restarts it.
    always_comb timer_d = (i_RX_DV || state_q == IDLE || state_q == DRAIN) ? 32'd0 : timer_q + 32'd1;
    assign timeout = !i_RX_DV && (state_q == LEN || state_q == PAYLOAD || state_q == CHK) && timer_q == TO_LAST;

    always_ff @(posedge i_Clock or negedge i_Rst_L)
        if (!i_Rst_L) begin
            timer_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            err_timeout_q <= timeout;
        end

    assign o_Err_Timeout = err_timeout_q;
`else
    assign timeout       = 1'b0;
    assign o_Err_Timeout = 1'b0;
`endif

    assign last         = rd_idx_q == len_q - 8'd1;
    assign o_Pyld_Valid = state_q == DRAIN;
    assign o_Pyld_Last  = o_Pyld_Valid && last;
    assign o_Pyld_Byte  = o_Pyld_Valid ? mem_q[rd_idx_q[AW-1:0]] : 8'd0;
    assign o_Pkt_Len    = o_Pyld_Valid ? len_q : 8'd0;
    assign o_Err_Chk    = err_chk_q;
    assign o_Err_Len    = err_len_q;
    assign o_Overrun    = overrun_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        rd_idx_d  = rd_idx_q;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        overrun_d = 1'b0;
        wr_en     = 1'b0;
        if (timeout) begin
            state_d = IDLE;
        end else if (state_q == DRAIN) begin
            overrun_d = i_RX_DV;
            if (i_Pyld_Ready) begin
                rd_idx_d = last ? 8'd0 : rd_idx_q + 8'd1;
                state_d  = last ? IDLE : DRAIN;
            end
        end else if (i_RX_DV) begin
            case (state_q)
                IDLE: state_d = (i_RX_Byte == SYNC_BYTE) ? LEN : IDLE;
                LEN: begin
                    len_d     = i_RX_Byte;
                    sum_d     = i_RX_Byte;
                    idx_d     = 8'd0;
                    err_len_d = i_RX_Byte == 8'd0 || i_RX_Byte > MAX_LEN_B;
                    state_d   = err_len_d ? IDLE : PAYLOAD;
                end
                PAYLOAD: begin
                    wr_en   = 1'b1;
                    sum_d   = sum_q + i_RX_Byte;
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == len_q - 8'd1) ? CHK : PAYLOAD;
                end
                CHK: begin
                    err_chk_d = i_RX_Byte != sum_q;
                    rd_idx_d  = 8'd0;
                    state_d   = err_chk_d ? IDLE : DRAIN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L)
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            len_q     <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            rd_idx_q  <= '0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            rd_idx_q  <= rd_idx_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            overrun_q <= overrun_d;
        end

    always_ff @(posedge i_Clock)
        if (wr_en) mem_q[idx_q[AW-1:0]] <= i_RX_Byte;
endmodule
